fir_out_requant: RTL

Output stage placed directly after the FIR filter. It takes the filter's full-width signed result every clock and keeps one sample out of every DECIM. Each kept sample is rounded and saturated down to the output word width. Results are buffered in a small FIFO and handed to the consumer over a valid/ready handshake; samples dropped because the FIFO was full are flagged.

---
 rtl/fir_out_requant.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fir_out_requant.sv
// FIR output stage: decimate, round-half-up, saturate to WIDTH_O bits, then
// buffer in a small first-word-fall-through FIFO behind a valid/ready port.
module fir_out_requant #(
    parameter int WIDTH_Y = 20,
    parameter int WIDTH_O = 8,
    parameter int SHIFT   = 8,
    parameter int DECIM   = 2,
    parameter int DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic signed [WIDTH_Y-1:0]   y_in,
    input  logic                        in_valid,
    input  logic                        clr,
    output logic signed [WIDTH_O-1:0]   out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        overflow,
    output logic [$clog2(DEPTH):0]      level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    // ---------------- decimation phase ----------------
    logic [PW-1:0] phase_reg;
    logic [PW-1:0] phase_next;
    logic          keep;

    assign keep = in_valid && (phase_reg == '0);

    always_comb begin
        phase_next = phase_reg;
        if (in_valid) begin
            if (phase_reg == PW'(DECIM - 1))
                phase_next = '0;
            else
                phase_next = phase_reg + 1'b1;
        end
    end

    // ---------------- rounding and saturation ----------------
    // One guard bit above the input keeps the rounding add from wrapping.
    logic signed [WIDTH_Y:0] y_ext;
    logic signed [WIDTH_Y:0] rnd_sum;
    logic signed [WIDTH_Y:0] r_shift;
    logic [WIDTH_Y-WIDTH_O+1:0] r_upper;
    logic                    sat_pos;
    logic                    sat_neg;
    logic [WIDTH_O-1:0]      sat_val;

    assign y_ext = {y_in[WIDTH_Y-1], y_in};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [WIDTH_Y:0] RND = {{WIDTH_Y{1'b0}}, 1'b1} << (SHIFT - 1);
            assign rnd_sum = y_ext + RND;
        end else begin : g_noround
            assign rnd_sum = y_ext;
        end
    endgenerate

    assign r_shift = rnd_sum >>> SHIFT;
    assign r_upper = r_shift[WIDTH_Y:WIDTH_O-1];

    // r fits in WIDTH_O bits exactly when all bits above the output sign agree with it
    assign sat_pos = ~r_shift[WIDTH_Y] & (|r_upper);
    assign sat_neg =  r_shift[WIDTH_Y] & ~(&r_upper);

    always_comb begin
        sat_val = r_shift[WIDTH_O-1:0];
        if (sat_pos)
            sat_val = {1'b0, {(WIDTH_O-1){1'b1}}};
        else if (sat_neg)
            sat_val = {1'b1, {(WIDTH_O-1){1'b0}}};
    end

    // ---------------- stage register and FIFO control ----------------
    logic               st_valid_reg;
    logic [WIDTH_O-1:0] st_data_reg;
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [LW-1:0]      level_reg;
    logic [LW-1:0]      level_next;
    logic               overflow_reg;
    logic [WIDTH_O-1:0] mem_reg [DEPTH];
    logic               pop;
    logic               push;
    logic               drop;

    assign pop        = (level_reg != '0) && out_ready;
    assign push       = st_valid_reg && ((level_reg != LW'(DEPTH)) || pop);
    assign drop       = st_valid_reg && !push;
    assign level_next = level_reg + LW'(push) - LW'(pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase_reg    <= '0;
            st_valid_reg <= 1'b0;
            st_data_reg  <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (clr) begin
            phase_reg    <= '0;
            st_valid_reg <= 1'b0;
            st_data_reg  <= sat_val;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            phase_reg    <= phase_next;
            st_valid_reg <= keep;
            st_data_reg  <= sat_val;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg    <= level_next;
            if (drop)
                overflow_reg <= 1'b1;
        end
    end

    // Storage is reset so that out_data reads 0 straight out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++)
                mem_reg[i] <= '0;
        end else if (!clr && push) begin
            mem_reg[wr_ptr_reg] <= st_data_reg;
        end
    end

    assign out_data  = mem_reg[rd_ptr_reg];
    assign out_valid = (level_reg != '0);
    assign overflow  = overflow_reg;
    assign level     = level_reg;

endmodule
